// File: rtl/pcm_dac_reader.sv
// Consumer end of the PCM sample FIFO: fetches one mono sample at a time and
// streams it to an audio DAC as a left-justified stereo frame (same sample on L and R).
module pcm_dac_reader #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_q,
  output logic             fifo_rdreq,
  output logic             dac_sclk,
  output logic             dac_lrclk,
  output logic             dac_sdata,
  output logic             underrun
);

  localparam int FRAME = 2 * WIDTH;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);
  localparam logic [BIT_W-1:0] R_FIRST  = BIT_W'(WIDTH);

  // hold_valid and rd_pending are mutually exclusive, so they share one state.
  typedef enum logic [1:0] {
    S_EMPTY,
    S_PENDING,
    S_HELD
  } fetch_state_e;

  fetch_state_e     state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [FRAME-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             sclk_q, sclk_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic             underrun_q, underrun_d;
  logic             tick, fall, frame_load, rd_issue;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q    <= S_EMPTY;
      div_cnt_q  <= '0;
      bit_cnt_q  <= BIT_LAST;
      shift_q    <= '0;
      hold_q     <= '0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    div_cnt_d  = div_cnt_q + 1'b1;
    sclk_d     = sclk_q;
    bit_cnt_d  = bit_cnt_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    shift_d    = shift_q;
    underrun_d = 1'b0;

    tick       = (div_cnt_q == DIV_LAST);
    fall       = tick && sclk_q;
    frame_load = fall && (bit_cnt_q == BIT_LAST);

    if (tick) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
    end

    // All serial outputs move on the sclk falling edge so the DAC samples mid-bit.
    if (fall) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      lrclk_d   = (bit_cnt_d >= R_FIRST);
      if (frame_load) begin
        if (state_q == S_HELD) begin
          shift_d = {hold_q, hold_q};
          sdata_d = hold_q[WIDTH-1];
        end else begin
          shift_d    = '0;
          sdata_d    = 1'b0;
          underrun_d = 1'b1;
        end
      end else begin
        shift_d = shift_q << 1;
        sdata_d = shift_q[FRAME-2];
      end
    end
  end

  // A capture coinciding with an empty-handed frame load still counts as underrun;
  // the captured word waits for the following frame.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rd_issue = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (!fifo_empty) begin
          rd_issue = 1'b1;
          state_d  = S_PENDING;
        end
      end
      S_PENDING: begin
        hold_d  = fifo_q;
        state_d = S_HELD;
      end
      S_HELD: begin
        if (frame_load) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign fifo_rdreq = rd_issue & ~aclr;
  assign dac_sclk   = sclk_q;
  assign dac_lrclk  = lrclk_q;
  assign dac_sdata  = sdata_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_pcm_dac_reader.sv
// Directed bench for pcm_dac_reader: a CLK_DIV=2 instance fed from a small FIFO
// model and a CLK_DIV=5 instance fed from an always-full source.
module tb_pcm_dac_reader;

  logic        clk  = 1'b0;
  logic        aclr = 1'b1;
  logic        fifoEmpty;
  logic [15:0] fifoQ = '0;
  logic        rdreqA, sclkA, lrA, sdataA, urA;
  logic        fifoEmptyB = 1'b0;
  logic [15:0] fifoQB = 16'hA5C3;
  logic        rdreqB, sclkB, lrB, sdataB, urB;

  logic [15:0] fifoMem [0:31];
  int wrPtr = 0, rdPtr = 0, popCount = 0;
  int checkCount = 0, passCount = 0;

  int cyc = 0, falls = 0, frameNum = 0, urNum = 0, firstRise = -1, firstFall = -1, runA = 1;
  int idxA = 0;
  int badRunA = 0, badSdataA = 0, badUrA = 0, badRdEmpty = 0, badRdWidth = 0;
  logic isFallA = 1'b0, prevSclkA = 1'b0, prevSdataA = 1'b0, prevRdA = 1'b0, curUnder = 1'b0;
  logic [31:0] sBits = '0, lBits = '0;
  logic [31:0] frameData [0:7];
  logic [31:0] frameLr [0:7];
  logic        frameUnder [0:7];
  int          urCycle [0:7];

  int runB = 1, badRunB = 0, badSdataB = 0, togglesB = 0, urCountB = 0;
  logic prevSclkB = 1'b0, prevSdataB = 1'b0;

  pcm_dac_reader #(.CLK_DIV(2), .WIDTH(16)) dutA (
    .clk(clk), .aclr(aclr), .fifo_empty(fifoEmpty), .fifo_q(fifoQ),
    .fifo_rdreq(rdreqA), .dac_sclk(sclkA), .dac_lrclk(lrA), .dac_sdata(sdataA),
    .underrun(urA)
  );

  pcm_dac_reader #(.CLK_DIV(5), .WIDTH(16)) dutB (
    .clk(clk), .aclr(aclr), .fifo_empty(fifoEmptyB), .fifo_q(fifoQB),
    .fifo_rdreq(rdreqB), .dac_sclk(sclkB), .dac_lrclk(lrB), .dac_sdata(sdataB),
    .underrun(urB)
  );

  always #5 clk = ~clk;

  assign fifoEmpty = (wrPtr <= rdPtr);

  // Normal-mode FIFO: q updates on the edge that samples rdreq.
  always @(posedge clk) begin
    if (aclr) popCount <= 0;
    else if (rdreqA) begin
      fifoQ    <= fifoMem[rdPtr % 32];
      rdPtr    <= rdPtr + 1;
      popCount <= popCount + 1;
    end
  end

  // Frame collector for dutA; cyc counts clk edges since reset release.
  always @(negedge clk) begin
    if (aclr) begin
      cyc = 0; falls = 0; frameNum = 0; urNum = 0;
      firstRise = -1; firstFall = -1; runA = 1;
      prevSclkA = 1'b0; prevSdataA = 1'b0; prevRdA = 1'b0;
    end else begin
      cyc++;
      isFallA = prevSclkA && !sclkA;
      idxA = falls % 32;
      if (!prevSclkA && sclkA && firstRise < 0) firstRise = cyc;
      if (isFallA && firstFall < 0) firstFall = cyc;
      if (sclkA != prevSclkA) begin
        if (runA != 2) badRunA++;
        runA = 1;
      end else runA++;
      if (sdataA != prevSdataA && !isFallA) badSdataA++;
      if (urA) begin
        if (!(isFallA && idxA == 0)) badUrA++;
        if (urNum < 8) urCycle[urNum] = cyc;
        urNum++;
      end
      if (rdreqA && fifoEmpty) badRdEmpty++;
      if (rdreqA && prevRdA) badRdWidth++;
      if (isFallA) begin
        if (idxA == 0) curUnder = urA;
        sBits[31-idxA] = sdataA;
        lBits[31-idxA] = lrA;
        falls++;
        if (idxA == 31 && frameNum < 8) begin
          frameData[frameNum]  = sBits;
          frameLr[frameNum]    = lBits;
          frameUnder[frameNum] = curUnder;
          frameNum++;
        end
      end
      prevSclkA = sclkA; prevSdataA = sdataA; prevRdA = rdreqA;
    end
  end

  always @(negedge clk) begin
    if (aclr) begin
      runB = 1; prevSclkB = 1'b0; prevSdataB = 1'b0;
    end else begin
      if (sclkB != prevSclkB) begin
        if (runB != 5) badRunB++;
        runB = 1;
      end else runB++;
      if (sdataB != prevSdataB) begin
        togglesB++;
        if (!(prevSclkB && !sclkB)) badSdataB++;
      end
      if (urB) urCountB++;
      prevSclkB = sclkB; prevSdataB = sdataB;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [15:0] word);
    fifoMem[wrPtr % 32] = word;
    wrPtr++;
  endtask

  // Holds reset for two cycles, checks the reset outputs, releases just after a negedge.
  task automatic startRun();
    aclr = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstOutputs", {27'b0, rdreqA, sclkA, lrA, sdataA, urA}, 32'h0);
    #1 aclr = 1'b0;
  endtask

  initial begin
    // Empty FIFO: free-running clocks, silent frames, one underrun per 128 clk.
    startRun();
    repeat (300) @(posedge clk);
    #1;
    checkOutput("emptyFirstRise", firstRise, 2);
    checkOutput("emptyFirstFall", firstFall, 4);
    checkOutput("emptyData0", frameData[0], 32'h0000_0000);
    checkOutput("emptyLr0", frameLr[0], 32'h0000_FFFF);
    checkOutput("emptyUrCount", urNum, 3);
    checkOutput("emptyUr0", urCycle[0], 4);
    checkOutput("emptyUr1", urCycle[1], 132);
    checkOutput("emptyPops", popCount, 0);

    aclr = 1'b1;
    applyStimulus(16'h3F7F);
    startRun();
    repeat (140) @(posedge clk);
    #1;
    checkOutput("preData0", frameData[0], 32'h3F7F_3F7F);
    checkOutput("preLr0", frameLr[0], 32'h0000_FFFF);
    checkOutput("preUnder0", frameUnder[0], 1'b0);
    checkOutput("prePops", popCount, 1);

    aclr = 1'b1;
    applyStimulus(16'h8001);
    applyStimulus(16'h0000);
    applyStimulus(16'hFFFF);
    startRun();
    repeat (400) @(posedge clk);
    #1;
    checkOutput("seqData0", frameData[0], 32'h8001_8001);
    checkOutput("seqData1", frameData[1], 32'h0000_0000);
    checkOutput("seqData2", frameData[2], 32'hFFFF_FFFF);
    checkOutput("seqUnder", {frameUnder[0], frameUnder[1], frameUnder[2]}, 3'b000);
    checkOutput("seqPops", popCount, 3);

    // Word becomes available so that it is captured on the frame-load edge at clk 132.
    startRun();
    repeat (130) @(posedge clk);
    #1 applyStimulus(16'hC35A);
    repeat (260) @(posedge clk);
    #1;
    checkOutput("wrapData1", frameData[1], 32'h0000_0000);
    checkOutput("wrapUnder1", frameUnder[1], 1'b1);
    checkOutput("wrapData2", frameData[2], 32'hC35A_C35A);
    checkOutput("wrapUnder2", frameUnder[2], 1'b0);
    checkOutput("wrapPops", popCount, 1);

    // Reset during the right channel with the popped word still in flight.
    startRun();
    repeat (79) @(posedge clk);
    #1 applyStimulus(16'hBEEF);
    @(posedge clk);
    #1;
    checkOutput("midLrRight", lrA, 1'b1);
    checkOutput("midPopped", popCount, 1);
    #1 aclr = 1'b1;
    #1 checkOutput("midAsyncRst", {27'b0, rdreqA, sclkA, lrA, sdataA, urA}, 32'h0);
    startRun();
    repeat (140) @(posedge clk);
    #1;
    checkOutput("midFirstRise", firstRise, 2);
    checkOutput("midFirstFall", firstFall, 4);
    checkOutput("midData0", frameData[0], 32'h0000_0000);
    checkOutput("midUnder0", frameUnder[0], 1'b1);
    checkOutput("midPops", popCount, 0);

    checkOutput("sclkHalfA", badRunA, 0);
    checkOutput("sdataEdgeA", badSdataA, 0);
    checkOutput("underrunPosA", badUrA, 0);
    checkOutput("rdreqWhileEmpty", badRdEmpty, 0);
    checkOutput("rdreqWidth", badRdWidth, 0);
    checkOutput("sclkHalfB", badRunB, 0);
    checkOutput("sdataEdgeB", badSdataB, 0);
    checkOutput("sdataActiveB", togglesB > 0, 1'b1);
    checkOutput("underrunB", urCountB, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
